// File: rtl/alu_multicycle_pkg.sv
// Shared ALU encodings and the execution FSM state type.
// Latency/backpressure: none, declarations only.
package alu_pkg;

  localparam int ALUCTRL_W = 4;

  localparam logic [ALUCTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALUCTRL_W-1:0] ALU_MULT = 4'b0011;
  localparam logic [ALUCTRL_W-1:0] ALU_DIV  = 4'b0100;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = 4'b0111;
  localparam logic [ALUCTRL_W-1:0] ALU_NOT  = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: WIDTH cycles after load; fin flags the last iteration, no backpressure (caller must not reload while active).
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int SHW = $clog2(WIDTH);

  logic             active;
  logic             div_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;

  assign fin = active && (cnt == SHW'(WIDTH - 1));

  // hi/lo hold partial-product:multiplier for MUL and remainder:dividend-quotient for DIV
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shl   = {hi, lo[WIDTH-1]};
    trial = shl - {1'b0, opb};
    if (div_q) begin
      if (!trial[WIDTH]) begin
        hi_nxt = trial[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = shl[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      div_q  <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
    end else if (load) begin
      active <= 1'b1;
      div_q  <= div_mode;
      cnt    <= '0;
      hi     <= '0;
      lo     <= div_mode ? a : b;
      opb    <= div_mode ? b : a;
    end else if (active) begin
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      cnt    <= cnt + SHW'(1);
      if (fin) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execution ALU: single-cycle logic/arith/shift ops, WIDTH-cycle MULT/DIV; optional ALU_OVF_EN adds ovf.
// Latency 1 (done the cycle after accept) or WIDTH for MULT/DIV; start is ignored while busy, nothing queues.
module alu_multicycle import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ALUCTRL_W-1:0] alucontrol,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result,
  output logic [WIDTH-1:0]     result_hi,
  output logic                 zero,
  output logic                 busy,
  output logic                 done,
`ifdef ALU_OVF_EN
  output logic                 ovf,
`endif
  output logic                 err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_n;
  logic             load, fin;
  logic             done_n, err_n;
  logic [WIDTH-1:0] res_n, hi_n;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic [WIDTH-1:0] sum, dif;
`ifdef ALU_OVF_EN
  logic             ovf_n;
`endif

  assign sum  = a + b;
  assign dif  = a - b;
  assign busy = (state != IDLE);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .div_mode (alucontrol == ALU_DIV),
    .a        (a),
    .b        (b),
    .fin      (fin),
    .hi_nxt   (eng_hi),
    .lo_nxt   (eng_lo)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    res_n   = result;
    hi_n    = result_hi;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef ALU_OVF_EN
    ovf_n   = ovf;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (alucontrol == ALU_MULT) begin
            load    = 1'b1;
            state_n = MUL;
          end else if (alucontrol == ALU_DIV && b != '0) begin
            load    = 1'b1;
            state_n = DIV;
          end else begin
            done_n = 1'b1;
            hi_n   = '0;
`ifdef ALU_OVF_EN
            ovf_n  = 1'b0;
`endif
            case (alucontrol)
              ALU_AND: res_n = a & b;
              ALU_OR:  res_n = a | b;
              ALU_ADD: begin
                res_n = sum;
`ifdef ALU_OVF_EN
                ovf_n = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif
              end
              ALU_SUB: begin
                res_n = dif;
`ifdef ALU_OVF_EN
                ovf_n = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
`endif
              end
              ALU_SLL: res_n = a << b[SHW-1:0];
              ALU_SRL: res_n = a >> b[SHW-1:0];
              ALU_NOT: res_n = ~a;
              // only divide-by-zero reaches here with ALU_DIV
              ALU_DIV: begin
                res_n = '1;
                hi_n  = a;
                err_n = 1'b1;
              end
              default: begin
                res_n = '0;
                err_n = 1'b1;
              end
            endcase
          end
        end
      end
      MUL, DIV: begin
        if (fin) begin
          state_n = IDLE;
          res_n   = eng_lo;
          hi_n    = eng_hi;
          done_n  = 1'b1;
`ifdef ALU_OVF_EN
          ovf_n   = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      result    <= res_n;
      result_hi <= hi_n;
      zero      <= (res_n == '0);
      done      <= done_n;
      err       <= err_n;
`ifdef ALU_OVF_EN
      ovf       <= ovf_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, multi-cycle corner sequences, randomized ops vs reference model.
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   alucontrol = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result, result_hi;
  logic         zero, busy, done, err;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
`ifdef ALU_OVF_EN
    .ovf        (ovf),
`endif
    .err        (err)
  );

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] x, y, r, h;
    logic         e, o;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from the operation definitions using wide arithmetic.
  function automatic void model(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] h,
                                output logic e, output logic o);
    logic [2*W-1:0] p;
    longint s;
    r = '0; h = '0; e = 1'b0; o = 1'b0;
    case (code)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        r = x + y;
        s = longint'($signed(x)) + longint'($signed(y));
        o = (s > SMAX) || (s < SMIN);
      end
      4'd3: begin
        p = {32'd0, x} * {32'd0, y};
        r = p[W-1:0];
        h = p[2*W-1:W];
      end
      4'd4: begin
        if (y == 0) begin r = '1; h = x; e = 1'b1; end
        else begin r = x / y; h = x % y; end
      end
      4'd5: r = x << y[4:0];
      4'd6: begin
        r = x - y;
        s = longint'($signed(x)) - longint'($signed(y));
        o = (s > SMAX) || (s < SMIN);
      end
      4'd7: r = x >> y[4:0];
      4'd8: r = ~x;
      default: e = 1'b1;
    endcase
  endfunction

  // Issues one op and returns in its done cycle with start low.
  task automatic run_op(input string name, input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] r, input logic [W-1:0] h, input logic e, input logic o);
    int bad;
    bit multi;
    multi = (code == 4'd3) || (code == 4'd4 && y != 0);
    alucontrol = code; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    if (multi) begin
      bad = 0;
      for (int i = 0; i < W; i++) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        if (i < W - 1) tick();
      end
      chk({name, "_busy_window"}, 64'(bad), 64'd0);
      tick();
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_result"}, 64'(result), 64'(r));
    chk({name, "_result_hi"}, 64'(result_hi), 64'(h));
    chk({name, "_err"}, 64'(err), 64'(e));
    chk({name, "_zero"}, 64'(zero), 64'(r == '0));
`ifdef ALU_OVF_EN
    chk({name, "_ovf"}, 64'(ovf), 64'(o));
`endif
  endtask

  initial begin
    logic [W-1:0] mr, mh, x, y;
    logic me, mo;
    logic [3:0] code;
    int bad;

    tbl[0]  = '{4'd2, 32'hFFFF_FFFF, 32'd1,          32'd0,          32'd0,          1'b0, 1'b0};
    tbl[1]  = '{4'd2, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b1};
    tbl[2]  = '{4'd6, 32'd3,         32'd5,          32'hFFFF_FFFE,  32'd0,          1'b0, 1'b0};
    tbl[3]  = '{4'd6, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0, 1'b1};
    tbl[4]  = '{4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  32'd0,          1'b0, 1'b0};
    tbl[5]  = '{4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0,  32'd0,          1'b0, 1'b0};
    tbl[6]  = '{4'd5, 32'd1,         32'd4,          32'd16,         32'd0,          1'b0, 1'b0};
    tbl[7]  = '{4'd7, 32'h8000_0000, 32'd31,         32'd1,          32'd0,          1'b0, 1'b0};
    tbl[8]  = '{4'd5, 32'd3,         32'h21,         32'd6,          32'd0,          1'b0, 1'b0};
    tbl[9]  = '{4'd3, 32'h0001_0000, 32'h0001_0000,  32'd0,          32'd1,          1'b0, 1'b0};
    tbl[10] = '{4'd3, 32'd7,         32'd6,          32'd42,         32'd0,          1'b0, 1'b0};
    tbl[11] = '{4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b0, 1'b0};
    tbl[12] = '{4'd4, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    tbl[13] = '{4'd4, 32'd5,         32'd7,          32'd0,          32'd5,          1'b0, 1'b0};
    tbl[14] = '{4'd4, 32'd9,         32'd0,          32'hFFFF_FFFF,  32'd9,          1'b1, 1'b0};
    tbl[15] = '{4'hF, 32'd123,       32'd4,          32'd0,          32'd0,          1'b1, 1'b0};
    tbl[16] = '{4'd8, 32'd0,         32'd55,         32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    tbl[17] = '{4'd8, 32'hA5A5_A5A5, 32'd0,          32'h5A5A_5A5A,  32'd0,          1'b0, 1'b0};

    // Reset state
    tick(); tick();
    chk("reset_result", {result, result_hi}, 64'd0);
    chk("reset_flags", 64'({zero, busy, done, err}), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 64'({busy, done}), 64'd0);

    // Directed vectors; each done pulse must drop next cycle while outputs hold
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].code, tbl[i].x, tbl[i].y, tbl[i].r, tbl[i].h, tbl[i].e, tbl[i].o);
      tick();
      chk($sformatf("vec%0d_done_drop", i), 64'({done, err}), 64'd0);
      chk($sformatf("vec%0d_hold", i), {result, result_hi}, {tbl[i].r, tbl[i].h});
    end

    // Reset asserted mid-MULT at iteration 10
    alucontrol = 4'd3; a = 32'd5; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_mult_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_result", {result, result_hi}, 64'd0);
    chk("rst_mid_flags", 64'({zero, busy, done, err}), 64'd0);
    tick(); tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst_abort_no_done", 64'(bad), 64'd0);
    run_op("after_reset_mult", 4'd3, 32'd5, 32'd3, 32'd15, 32'd0, 1'b0, 1'b0);
    tick();

    // start held with SLL during a DIV: ignored until the DIV's done cycle
    alucontrol = 4'd4; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    alucontrol = 4'd5; a = 32'd1; b = 32'd4;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i < W - 1) tick();
    end
    chk("held_start_ignored", 64'(bad), 64'd0);
    tick();
    chk("held_div_done", 64'({done, busy, err}), 64'b100);
    chk("held_div_result", {result_hi, result}, {32'd2, 32'd14});
    tick();
    start = 1'b0;
    chk("held_sll_done", 64'({done, busy, err}), 64'b100);
    chk("held_sll_result", {result_hi, result}, {32'd0, 32'd16});
    tick();
    chk("held_sll_done_drop", 64'(done), 64'd0);

    // Randomized back-to-back ops against the reference model
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) code = 4'($urandom_range(3, 4));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y = y % 32'd1000;
      if ($urandom_range(0, 7) == 0) y = '0;
      model(code, x, y, mr, mh, me, mo);
      run_op($sformatf("rnd%0d_op%0d", i, code), code, x, y, mr, mh, me, mo);
    end
    tick();
    chk("final_done_drop", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
